// File: rtl/clkdiv_multi.sv
// clkdiv_multi: independent runtime-programmable clock dividers off CLK100MHZ.
// Each channel emits a near-50% divided clock, a wrap tick and a pending flag.
// A divisor change is held back until the next period boundary, so there are no runt pulses.
module clkdiv_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 25
) (
  input  logic                    CLK100MHZ,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  localparam int unsigned     EXT_W   = DIV_W + 1;
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_N   = (DEF_DIV < DIV_MIN) ? DIV_MIN : DEF_DIV;
  localparam logic [DIV_W-1:0] DEF_CNT = DEF_N - DIV_W'(1);

  // Divisors below 2 cannot make a clock, so they behave as 2
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  // High-phase length; odd divisors get the extra cycle high
  function automatic logic [EXT_W-1:0] high_len(input logic [DIV_W-1:0] n);
    return ({1'b0, n} + EXT_W'(1)) >> 1;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] n_cur, n_use, cnt_inc;
    logic [EXT_W-1:0] h_use;
    logic             wrap;

    // Next-state: count or park at N-1, swap in pending divisor at boundaries, capture loads
    always_comb begin
      n_cur      = eff_div(div_act_q);
      n_use      = n_cur;
      wrap       = (cnt_q == n_cur - DIV_W'(1));
      cnt_inc    = '0;
      h_use      = '0;
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      div_pend_d = div_pend_q;
      pend_d     = pend_q;
      clk_d      = 1'b0;
      tick_d     = 1'b0;

      if (ch_en[i]) begin
        if (wrap && pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
          n_use     = eff_div(div_pend_q);
        end
        cnt_inc = wrap ? '0 : cnt_q + DIV_W'(1);
        h_use   = high_len(n_use);
        cnt_d   = cnt_inc;
        clk_d   = ({1'b0, cnt_inc} < h_use);
        tick_d  = (cnt_inc == '0);
      end else begin
        if (pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
          n_use     = eff_div(div_pend_q);
        end
        cnt_d = n_use - DIV_W'(1);
      end

      // A load on a wrap edge stays pending: the wrap above used the older value
      if (div_load[i]) begin
        div_pend_d = div_in[i*DIV_W +: DIV_W];
        pend_d     = 1'b1;
      end
    end

    // Channel state and registered outputs
    always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
        cnt_q      <= DEF_CNT;
        div_act_q  <= DEF_DIV;
        div_pend_q <= '0;
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        div_act_q  <= div_act_d;
        div_pend_q <= div_pend_d;
        pend_q     <= pend_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised multi-channel clock divider driven from the 100 MHz board clock. Each channel produces a registered near-50%-duty divided clock and a one-cycle tick strobe. Each channel's divisor can be changed at runtime without glitches, and each channel has its own enable. It is the general-purpose replacement for fixed single-rate dividers such as the 4 MHz generator: with default parameters, every channel outputs 4 MHz.

## Interface

Parameters:
- NUM_CH, 4: number of independent channels (1..16).
- DIV_W, 16: divisor width in bits (2..32).
- DEFAULT_DIV, 25: divisor loaded at reset (25 gives 4 MHz from 100 MHz).

Ports:
- CLK100MHZ  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- div_in  in  NUM_CH*DIV_W  divisor values; channel i uses bits [i*DIV_W +: DIV_W].
- div_load  in  NUM_CH  per-channel load strobe; captures that channel's div_in slice.
- ch_en  in  NUM_CH  per-channel run enable (level).
- clk_out  out  NUM_CH  divided clock, registered.
- tick  out  NUM_CH  one-cycle strobe, high in the cycle clk_out rises.
- pending  out  NUM_CH  high while a loaded divisor waits to take effect.

## Operation

Per-channel state:
- cnt[DIV_W]: position within the period.
- div_act: active divisor.
- div_pend: pending divisor.
- pend flag: drives the pending output.

Divisor rules:
- Effective divisor N is div_act clamped to a minimum of 2. Values 0 and 1 behave as 2.
- High count H = (N+1)>>1, so odd N gives one extra high cycle.
- Example: N=25 gives 13 cycles high and 12 cycles low.

Reset:
- cnt = N(DEFAULT_DIV)-1.
- div_act = DEFAULT_DIV.
- div_pend = 0, pend = 0.
- clk_out = 0, tick = 0.

Enabled channel, each edge:
- cnt_next = (cnt == N-1) ? 0 : cnt+1.
- clk_out <= (cnt_next < H).
- tick <= (cnt_next == 0).
- The output period is exactly N cycles.

Disabled channel (ch_en=0), each edge:
- cnt <= N-1, clk_out <= 0, tick <= 0.
- The channel therefore resumes phase-aligned: on the first enabled edge cnt wraps to 0, and clk_out=1 and tick=1 together.

Divisor load:
- div_load[i]=1 captures the div_in slice into div_pend and sets pend on the same edge.
- Enabled channel: the pending value is applied only at a period boundary. On the edge where cnt wraps N-1 to 0 and pend=1, div_act <= div_pend and pend <= 0. The new N governs the period starting at that edge, so H and the wrap point use the new value from cnt=0 onward.
- Disabled channel: pend=1 applies on the next edge (div_act <= div_pend, pend <= 0). cnt tracks the new N-1.
- Load while pend=1: div_pend is overwritten. Only the last value is applied, with no intermediate period.
- Load on the same edge as a wrap: the wrap applies the previously registered div_pend (if pend was 1). The newly captured value remains pending until the next wrap.
- Disable while pend=1: the pending value applies on the next disabled edge.

Channels are fully independent; there is no cross-channel phase relation except a common reset.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- ch_en rising at edge k gives clk_out=1 and tick=1 after edge k (1-cycle latency).
- ch_en falling at edge k gives clk_out=0 after edge k.
- A new divisor takes effect 1..N_old cycles after the load edge. The boundary period is a complete old-N period followed by a complete new-N period, with no runt pulses.
- tick is exactly one cycle wide at every wrap, including N=2, where tick is high every other cycle.
- Asynchronous rst mid-period: all outputs drop to 0 immediately. After release, behaviour matches the enable sequence, with the first wrap occurring on the first edge where ch_en=1.

## Test plan

- Reset, all ch_en=1, defaults: each clk_out has period 25 with 13 high / 12 low; tick once per 25 cycles, coincident with clk_out rising; pending=0.
- Channel 1 div_load with 10 mid-period: pending[1]=1 until the next wrap; the old 25-cycle period completes, then 5-high/5-low periods follow; channels 0, 2, 3 are unaffected.
- Divisors 0, 1, 2, 3 on separate channels: patterns 1H1L, 1H1L, 1H1L, 2H1L; tick every 2, 2, 2, 3 cycles.
- Two loads (8 then 12) within one period: no 8-cycle period appears; the next period is 12; pending clears at that wrap.
- ch_en toggled low for 7 cycles mid-high-phase: clk_out=0 on the next edge; on re-enable clk_out and tick are high on the first enabled edge, followed by the full H high cycles.
- rst asserted asynchronously mid-cycle: clk_out, tick and pending go 0 without waiting for a clock edge; after release the divisor is back to 25.
